// File: rtl/data_mem_arbiter.sv
// Arbitrates the single DataMemory port between the CPU MEM stage and a DMA/debug port.
// Optional performance counters are enabled by defining DATA_MEM_ARB_PERF_EN.
module data_mem_arbiter #(
  parameter int MAX_STREAK = 4,
  parameter int CNT_W      = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cMemRead,
  input  logic [1:0]  cMemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadReg2,
  output logic        ocCpuStall,
  output logic [31:0] oCpuReadData,
  input  logic        DmaReq,
  input  logic        DmaRead,
  input  logic [1:0]  DmaWrite,
  input  logic [31:0] DmaAddr,
  input  logic [31:0] DmaWData,
  output logic        oDmaAck,
  output logic [31:0] oDmaRData,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  output logic [1:0]  ocMemWrite,
  output logic        ocMemRead,
  input  logic [31:0] MemReadData,
  output logic [31:0] oStallCount,
  output logic [31:0] oDmaCount
);

  typedef enum logic {
    ARB = 1'b0,
    ACK = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] MaxStreak = CNT_W'(MAX_STREAK);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic             dma_ack_q, dma_ack_d;
  logic [31:0]      dma_rdata_q, dma_rdata_d;

  logic cpu_req;
  logic dma_grant;
  logic cpu_grant;

  assign cpu_req   = cMemRead | (cMemWrite != 2'b00);
  // In ACK the DMA request is ignored, so the CPU is guaranteed progress after a forced stall.
  assign dma_grant = (state_q == ARB) & DmaReq & (~cpu_req | (streak_q == MaxStreak));
  assign cpu_grant = cpu_req & ~dma_grant;

  assign ocCpuStall   = cpu_req & dma_grant;
  assign oCpuReadData = MemReadData;
  assign oDmaAck      = dma_ack_q;
  assign oDmaRData    = dma_rdata_q;

  always_comb begin
    oMemAddr   = '0;
    oMemWData  = '0;
    ocMemWrite = '0;
    ocMemRead  = 1'b0;
    if (dma_grant) begin
      oMemAddr   = DmaAddr;
      oMemWData  = DmaWData;
      ocMemWrite = DmaWrite;
      ocMemRead  = DmaRead;
    end else if (cpu_grant) begin
      oMemAddr   = ALUResult;
      oMemWData  = ReadReg2;
      ocMemWrite = cMemWrite;
      ocMemRead  = cMemRead;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    dma_ack_d   = dma_grant;
    dma_rdata_d = dma_rdata_q;

    case (state_q)
      ARB:     if (dma_grant) state_d = ACK;
      ACK:     state_d = ARB;
      default: state_d = ARB;
    endcase

    if (dma_grant) begin
      streak_d    = '0;
      dma_rdata_d = MemReadData;
    end else if (!DmaReq) begin
      streak_d = '0;
    end else if (cpu_grant && (streak_q != MaxStreak)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= ARB;
      streak_q    <= '0;
      dma_ack_q   <= 1'b0;
      // NOTE: the read-data holding register is reset too, so oDmaRData is defined out of reset.
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      dma_ack_q   <= dma_ack_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

`ifdef DATA_MEM_ARB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] dma_cnt_q, dma_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    dma_cnt_d   = dma_cnt_q;
    if (ocCpuStall) stall_cnt_d = stall_cnt_q + 32'd1;
    if (dma_ack_q)  dma_cnt_d   = dma_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stall_cnt_q <= '0;
      dma_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      dma_cnt_q   <= dma_cnt_d;
    end
  end

  assign oStallCount = stall_cnt_q;
  assign oDmaCount   = dma_cnt_q;
`else
  assign oStallCount = '0;
  assign oDmaCount   = '0;
`endif

endmodule
